maze_player_mover: RTL

- Downstream consumer of the maze generator's RAM read port. After `gen_end`, it holds the player position and accepts one-cycle direction pulses.
- For each move it reads the target tile from maze RAM and moves the player only if that tile is FLOOR (0).
- It flags a win when the player reaches the bottom row, which is only enterable through the exit opening.
- Position outputs feed the renderer and game controller.

---
 rtl/maze_player_mover_if.sv | 27 ++
 rtl/maze_player_mover.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/maze_player_mover_if.sv
// Player-mover bus: generator status, move requests, maze RAM read port and player outputs.
// master = game controller / generator side, slave = maze_player_mover.
interface maze_player_mover_if;
  logic        gen_end;
  logic        move_up;
  logic        move_down;
  logic        move_left;
  logic        move_right;
  logic [10:0] maze_address;
  logic        maze_data;
  logic [5:0]  player_x;
  logic [5:0]  player_y;
  logic        busy;
  logic        bumped;
  logic        won;
  logic [15:0] move_count;

  modport master (
    output gen_end, move_up, move_down, move_left, move_right, maze_data,
    input  maze_address, player_x, player_y, busy, bumped, won, move_count
  );

  modport slave (
    input  gen_end, move_up, move_down, move_left, move_right, maze_data,
    output maze_address, player_x, player_y, busy, bumped, won, move_count
  );
endinterface

// File: rtl/maze_player_mover.sv
// Player position tracker: resolves one-cycle move pulses against maze RAM after generation.
// Optional macro MAZE_MOVE_COUNTER_EN enables the saturating accepted-move counter.
//
// state  | meaning
// IDLE   | maze not valid, player held at start
// READY  | sampling move pulses
// FETCH  | target address on the RAM port, load latency counter
// WAIT   | waiting for RAM read latency
// DECIDE | maze_data valid: move or bump
// WON    | player on bottom row, moves ignored
module maze_player_mover #(
  parameter int WIDTH      = 30,
  parameter int HEIGHT     = 40,
  parameter int START_X    = 0,
  parameter int START_Y    = 0,
  parameter int RD_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  maze_player_mover_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_READY, S_FETCH, S_WAIT, S_DECIDE, S_WON
  } state_t;

  localparam logic [5:0] X0       = 6'(START_X);
  localparam logic [5:0] Y0       = 6'(START_Y);
  localparam logic [5:0] X_LAST   = 6'(WIDTH - 1);
  localparam logic [5:0] Y_LAST   = 6'(HEIGHT - 1);
  localparam logic [2:0] LAT_INIT = 3'(RD_LATENCY - 1);

  function automatic logic [10:0] addr_of(input logic [5:0] x, input logic [5:0] y);
    return 11'(WIDTH) * 11'(y) + 11'(x);
  endfunction

  localparam logic [10:0] ADDR0 = 11'(WIDTH * START_Y + START_X);

  state_t      state_q, state_d;
  logic [5:0]  px_q, px_d, py_q, py_d, tx_q, tx_d, ty_q, ty_d;
  logic [10:0] addr_q, addr_d;
  logic [2:0]  lat_q, lat_d;
  logic        busy_q, busy_d, bumped_q, bumped_d, won_q, won_d;

  logic [3:0]  mv;
  logic        one_hot, oob;
  logic [5:0]  tx, ty;
  logic        accept;

  assign mv      = {bus.move_up, bus.move_down, bus.move_left, bus.move_right};
  assign one_hot = $onehot(mv);
  assign accept  = (state_q == S_DECIDE) && !bus.maze_data;

  // Bounds are checked before any subtraction so coordinates never wrap.
  always_comb begin
    tx  = px_q;
    ty  = py_q;
    oob = 1'b0;
    if (bus.move_up) begin
      oob = (py_q == 6'd0);
      ty  = oob ? py_q : py_q - 6'd1;
    end else if (bus.move_down) begin
      oob = (py_q == Y_LAST);
      ty  = oob ? py_q : py_q + 6'd1;
    end else if (bus.move_left) begin
      oob = (px_q == 6'd0);
      tx  = oob ? px_q : px_q - 6'd1;
    end else if (bus.move_right) begin
      oob = (px_q == X_LAST);
      tx  = oob ? px_q : px_q + 6'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      px_q     <= X0;
      py_q     <= Y0;
      tx_q     <= X0;
      ty_q     <= Y0;
      addr_q   <= ADDR0;
      lat_q    <= 3'd0;
      busy_q   <= 1'b0;
      bumped_q <= 1'b0;
      won_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      px_q     <= px_d;
      py_q     <= py_d;
      tx_q     <= tx_d;
      ty_q     <= ty_d;
      addr_q   <= addr_d;
      lat_q    <= lat_d;
      busy_q   <= busy_d;
      bumped_q <= bumped_d;
      won_q    <= won_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!bus.gen_end) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_d = S_READY;
        S_READY:  if (one_hot && !oob) state_d = S_FETCH;
        S_FETCH:  state_d = (RD_LATENCY == 1) ? S_DECIDE : S_WAIT;
        S_WAIT:   if (lat_q <= 3'd1) state_d = S_DECIDE;
        S_DECIDE: state_d = (accept && ty_q == Y_LAST) ? S_WON : S_READY;
        S_WON:    state_d = S_WON;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    px_d     = px_q;
    py_d     = py_q;
    tx_d     = tx_q;
    ty_d     = ty_q;
    addr_d   = addr_q;
    lat_d    = lat_q;
    busy_d   = busy_q;
    bumped_d = 1'b0;
    won_d    = won_q;
    if (!bus.gen_end) begin
      px_d   = X0;
      py_d   = Y0;
      tx_d   = X0;
      ty_d   = Y0;
      addr_d = ADDR0;
      lat_d  = 3'd0;
      busy_d = 1'b0;
      won_d  = 1'b0;
    end else begin
      case (state_q)
        S_READY: begin
          if (one_hot) begin
            if (oob) begin
              bumped_d = 1'b1;
            end else begin
              tx_d   = tx;
              ty_d   = ty;
              addr_d = addr_of(tx, ty);
              busy_d = 1'b1;
            end
          end
        end
        S_FETCH: lat_d = LAT_INIT;
        S_WAIT:  if (lat_q != 3'd0) lat_d = lat_q - 3'd1;
        S_DECIDE: begin
          busy_d = 1'b0;
          if (accept) begin
            px_d   = tx_q;
            py_d   = ty_q;
            addr_d = addr_of(tx_q, ty_q);
            won_d  = (ty_q == Y_LAST);
          end else begin
            bumped_d = 1'b1;
            addr_d   = addr_of(px_q, py_q);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MAZE_MOVE_COUNTER_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!bus.gen_end) cnt_d = 16'd0;
    else if (accept && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= 16'd0;
    else       cnt_q <= cnt_d;
  end

  assign bus.move_count = cnt_q;
`else
  assign bus.move_count = 16'd0;
`endif

  assign bus.maze_address = addr_q;
  assign bus.player_x     = px_q;
  assign bus.player_y     = py_q;
  assign bus.busy         = busy_q;
  assign bus.bumped       = bumped_q;
  assign bus.won          = won_q;

endmodule
